// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs each MEM-stage data access over a req/ack memory port.
// The upstream pipeline is frozen while the access is outstanding. Load data is
// registered for the MEM/WB boundary. A wait counter aborts an unanswered request
// and raises a sticky error. A saturating counter tracks the number of stall cycles.
module mem_access_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_MEM,
   input  logic              memWrite_MEM,
   input  logic [DATA_W-1:0] ALUresult_MEM,
   input  logic [DATA_W-1:0] editData_MEM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [DATA_W-1:0] readData_MEM,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  stall_count
);

   localparam int WCNT_W = $clog2(TIMEOUT);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt;
   logic              timeout_hit;

   // The abort fires in the final cycle the request is allowed to wait. An ack
   // that arrives in the same cycle is still accepted, because it is checked first.
   assign timeout_hit = (wait_cnt == WAIT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state. DONE always returns to IDLE, so the completing instruction,
   // which still has enable_MEM high, is not issued a second time.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable_MEM) state_d = REQ;
         REQ:     if (mem_ack || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall is decoded from the state. In IDLE, a new access stalls combinationally.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:    stall = enable_MEM;
         REQ:     stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   // Registered memory port, load data, error flag, wait counter and stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         readData_MEM <= '0;
         err_timeout  <= 1'b0;
         stall_count  <= '0;
         wait_cnt     <= '0;
      end else begin
         if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
         case (state_q)
            IDLE: begin
               if (enable_MEM) begin
                  mem_addr  <= ALUresult_MEM;
                  mem_wdata <= editData_MEM;
                  mem_we    <= memWrite_MEM;
                  mem_req   <= 1'b1;
                  wait_cnt  <= '0;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (!mem_we) readData_MEM <= mem_rdata;
               end else if (timeout_hit) begin
                  mem_req      <= 1'b0;
                  mem_we       <= 1'b0;
                  err_timeout  <= 1'b1;
                  readData_MEM <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. It applies a table of directed accesses and a few
// hand-written reset/idle sequences. It then runs random accesses against a
// transaction-level model.
module tb_mem_access_ctrl;

   localparam int DW = 32;
   localparam int TO = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable_MEM, memWrite_MEM, mem_ack;
   logic [DW-1:0] ALUresult_MEM, editData_MEM, mem_rdata;
   logic          mem_req, mem_we, stall, err_timeout;
   logic [DW-1:0] mem_addr, mem_wdata, readData_MEM;
   logic [CW-1:0] stall_count;

   mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .enable_MEM(enable_MEM), .memWrite_MEM(memWrite_MEM),
      .ALUresult_MEM(ALUresult_MEM), .editData_MEM(editData_MEM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .readData_MEM(readData_MEM), .err_timeout(err_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Transaction-level expectations: running stall total, last load value, sticky error
   longint        m_cnt;
   logic [DW-1:0] m_rd;
   logic          m_err;

   typedef struct {
      logic          st;
      logic [DW-1:0] a, wd, rd;
      int            k;          // ack on the k-th request cycle; 0 means never ack
      int            exp_req, exp_stall;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      int            exp_cnt;
      int            gap;        // idle cycles after the access
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; enable_MEM = 1'b0; mem_ack = 1'b0; memWrite_MEM = 1'b0;
      ALUresult_MEM = '0; editData_MEM = '0; mem_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_cnt = 0; m_rd = '0; m_err = 1'b0;
   endtask

   // Drive one access starting at the next negedge. Acknowledge it on the k-th
   // cycle in which mem_req is seen high. Return when stall drops (DONE), leaving
   // enable_MEM high through DONE the way a frozen pipeline would.
   task automatic do_access(input logic st, input logic [DW-1:0] a, wd, rd, input int k,
                            output int req_c, output int stall_c, output logic stable_ok,
                            output logic done);
      int cyc;
      req_c = 0; stall_c = 0; stable_ok = 1'b1; done = 1'b0; cyc = 0;
      @(negedge clk);
      enable_MEM = 1'b1; memWrite_MEM = st; ALUresult_MEM = a; editData_MEM = wd;
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1 if (stall) stall_c++;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         mem_ack = 1'b0;
         mem_rdata = $urandom;
         // Scramble the upstream inputs so that a design which fails to latch them shows up
         ALUresult_MEM = $urandom; editData_MEM = $urandom; memWrite_MEM = 1'($urandom);
         if (mem_req) begin
            req_c++;
            if (mem_addr !== a || mem_wdata !== wd || mem_we !== st) stable_ok = 1'b0;
            if (req_c == k) begin mem_ack = 1'b1; mem_rdata = rd; end
         end
         #1 if (stall) stall_c++; else done = 1'b1;
      end
   endtask

   // Idle cycles with enable_MEM low. Stray acks are optionally injected and must be ignored.
   task automatic idle(input int n, input logic stray, output logic quiet);
      quiet = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enable_MEM = 1'b0;
         mem_ack = stray ? 1'($urandom) : 1'b0;
         mem_rdata = $urandom;
         #1 if (stall || mem_req) quiet = 1'b0;
      end
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   // Run one access, then check it against the expected values
   task automatic run_check(input string tag, input logic st, input logic [DW-1:0] a, wd, rd,
                            input int k, input int e_req, input int e_stall,
                            input logic [DW-1:0] e_rd, input logic e_err, input longint e_cnt);
      int rq, sc; logic ok, dn;
      do_access(st, a, wd, rd, k, rq, sc, ok, dn);
      chk({tag, " done"}, 64'(dn), 64'd1);
      chk({tag, " req_cycles"}, 64'(rq), 64'(e_req));
      chk({tag, " stall_cycles"}, 64'(sc), 64'(e_stall));
      chk({tag, " port_stable"}, 64'(ok), 64'd1);
      chk({tag, " readData"}, 64'(readData_MEM), 64'(e_rd));
      chk({tag, " err_timeout"}, 64'(err_timeout), 64'(e_err));
      chk({tag, " stall_count"}, 64'(stall_count), 64'(e_cnt));
   endtask

   initial begin
      logic q;
      reset = 1'b1; enable_MEM = 1'b0; memWrite_MEM = 1'b0; mem_ack = 1'b0;
      ALUresult_MEM = '0; editData_MEM = '0; mem_rdata = '0;

      //          st    addr          wdata         rdata         k   req stall exp_rd        err cnt gap
      tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1,  1,  2, 32'hDEAD_BEEF, 1'b0,  2, 2};
      tbl[1] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 32'hAAAA_5555, 3, 3,  4, 32'hDEAD_BEEF, 1'b0,  6, 2};
      tbl[2] = '{1'b0, 32'h0000_0080, 32'h0,        32'h0BAD_F00D, 1,  1,  2, 32'h0BAD_F00D, 1'b0,  8, 0};
      tbl[3] = '{1'b1, 32'h0000_0084, 32'hCAFE_F00D, 32'h7777_7777, 1, 1,  2, 32'h0BAD_F00D, 1'b0, 10, 2};
      tbl[4] = '{1'b0, 32'h0000_0200, 32'h0,        32'h5566_7788, 16, 16, 17, 32'h5566_7788, 1'b0, 27, 2};
      tbl[5] = '{1'b0, 32'h0000_0100, 32'h0,        32'h9999_9999, 0,  16, 17, 32'h0,        1'b1, 44, 2};
      tbl[6] = '{1'b0, 32'h0000_0104, 32'h0,        32'h1122_3344, 2,  2,  3, 32'h1122_3344, 1'b1, 47, 2};
      tbl[7] = '{1'b1, 32'h0000_0108, 32'hF0F0_0F0F, 32'h3333_3333, 5, 5,  6, 32'h1122_3344, 1'b1, 53, 2};

      do_reset();
      #1;
      chk("rst mem_req", 64'(mem_req), 64'd0);
      chk("rst mem_we", 64'(mem_we), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst readData", 64'(readData_MEM), 64'd0);
      chk("rst err", 64'(err_timeout), 64'd0);
      chk("rst stall_count", 64'(stall_count), 64'd0);
      chk("rst stall", 64'(stall), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_check($sformatf("tbl%0d", i), tbl[i].st, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].k,
                   tbl[i].exp_req, tbl[i].exp_stall, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_cnt);
         if (tbl[i].gap > 0) begin
            idle(tbl[i].gap, 1'b1, q);
            chk($sformatf("tbl%0d idle_quiet", i), 64'(q), 64'd1);
            chk($sformatf("tbl%0d readData_hold", i), 64'(readData_MEM), 64'(tbl[i].exp_rd));
         end
      end

      // Ten cycles with no memory instruction: no stall, no request, counter frozen
      idle(10, 1'b0, q);
      chk("nomem quiet", 64'(q), 64'd1);
      chk("nomem stall_count", 64'(stall_count), 64'd53);
      chk("nomem err_sticky", 64'(err_timeout), 64'd1);

      // Reset during the second REQ cycle, followed by a late ack
      @(negedge clk);
      enable_MEM = 1'b1; memWrite_MEM = 1'b0; ALUresult_MEM = 32'h300; mem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; enable_MEM = 1'b0;
      #1;
      chk("midrst mem_req", 64'(mem_req), 64'd0);
      chk("midrst stall", 64'(stall), 64'd0);
      chk("midrst err", 64'(err_timeout), 64'd0);
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("midrst stray_ack readData", 64'(readData_MEM), 64'd0);
      chk("midrst stall_count", 64'(stall_count), 64'd0);
      chk("midrst mem_req_idle", 64'(mem_req), 64'd0);
      run_check("after_rst", 1'b0, 32'h44, 32'h0, 32'hABCD_0123, 1, 1, 2, 32'hABCD_0123, 1'b0, 2);
      idle(1, 1'b0, q);

      // Random accesses against the transaction-level model
      do_reset();
      for (int n = 0; n < 40; n++) begin
         logic st; logic [DW-1:0] a, wd, rd; int k, e_req; bit to;
         st = 1'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
         k  = $urandom_range(0, TO + 3);
         to = (k == 0) || (k > TO);
         e_req = to ? TO : k;
         if (to) begin m_rd = '0; m_err = 1'b1; end
         else if (!st) m_rd = rd;
         m_cnt += e_req + 1;
         run_check($sformatf("rnd%0d", n), st, a, wd, rd, k, e_req, e_req + 1, m_rd, m_err, m_cnt);
         k = $urandom_range(0, 3);
         if (k > 0) begin
            idle(k, 1'b1, q);
            chk($sformatf("rnd%0d idle_quiet", n), 64'(q), 64'd1);
            chk($sformatf("rnd%0d readData_hold", n), 64'(readData_MEM), 64'(m_rd));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
